// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared widths, operand bundle and constants for the EX
//                operand-preparation stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam int EX_WIDTH = 16;
    localparam int EX_RAW   = 4;

    localparam logic [EX_RAW-1:0] REG_ZERO = '0;

    // One slot of the output/skid storage: exactly what the adder consumes.
    typedef struct packed {
        logic [EX_WIDTH-1:0] x;
        logic [EX_WIDTH-1:0] y;
        logic                op;
        logic [EX_RAW-1:0]   dest;
    } operand_t;

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Per-operand forwarding select; EX/MEM beats MEM/WB and
//                register zero is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import ex_pkg::*;
#(
    parameter int WIDTH = ex_pkg::EX_WIDTH,
    parameter int RAW   = ex_pkg::EX_RAW
) (
    input  logic [RAW-1:0]   src_addr,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             exmem_we,
    input  logic [RAW-1:0]   exmem_rd,
    input  logic [WIDTH-1:0] exmem_data,
    input  logic             memwb_we,
    input  logic [RAW-1:0]   memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    output logic [WIDTH-1:0] fwd_data,
    output logic             fwd_hit
);

    logic w_nonzero;
    logic w_exmem_hit;
    logic w_memwb_hit;

    always_comb begin
        w_nonzero   = (src_addr != REG_ZERO);
        w_exmem_hit = exmem_we && (exmem_rd == src_addr) && w_nonzero;
        w_memwb_hit = memwb_we && (memwb_rd == src_addr) && w_nonzero;
        fwd_hit     = w_exmem_hit || w_memwb_hit;
        if (w_exmem_hit) begin
            fwd_data = exmem_data;
        end else if (w_memwb_hit) begin
            fwd_data = memwb_data;
        end else begin
            fwd_data = reg_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage
//  Description : Forwarding, Y select and subtract pre-inversion in front of
//                the ripple adder, registered behind a 2-entry skid buffer.
//                Optional macro EX_OPERAND_FWD_CNT_EN adds fwd_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = ex_pkg::EX_WIDTH,
    parameter int RAW   = ex_pkg::EX_RAW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RAW-1:0]   rs_addr,
    input  logic [RAW-1:0]   rt_addr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic             sub,
    input  logic [RAW-1:0]   dest_in,
    input  logic             exmem_we,
    input  logic             memwb_we,
    input  logic [RAW-1:0]   exmem_rd,
    input  logic [RAW-1:0]   memwb_rd,
    input  logic [WIDTH-1:0] exmem_data,
    input  logic [WIDTH-1:0] memwb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             op_out,
`ifdef EX_OPERAND_FWD_CNT_EN
    output logic [15:0]      fwd_cnt,
`endif
    output logic [RAW-1:0]   dest_out
);

    logic [WIDTH-1:0] w_rs_fwd;
    logic [WIDTH-1:0] w_rt_fwd;
    logic             w_rs_hit;
    logic             w_rt_hit;
    logic [WIDTH-1:0] w_yb;
    logic             w_accept;
    operand_t         w_new;

    operand_t r_prim;
    operand_t r_skid;
    logic     r_prim_valid;
    logic     r_skid_valid;
    logic     r_in_ready;

    operand_t w_prim_nxt;
    operand_t w_skid_nxt;
    logic     w_prim_valid_nxt;
    logic     w_skid_valid_nxt;

    fwd_mux #(.WIDTH(WIDTH), .RAW(RAW)) u_fwd_rs (
        .src_addr   (rs_addr),
        .reg_data   (rs_data),
        .exmem_we   (exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_we   (memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .fwd_data   (w_rs_fwd),
        .fwd_hit    (w_rs_hit)
    );

    fwd_mux #(.WIDTH(WIDTH), .RAW(RAW)) u_fwd_rt (
        .src_addr   (rt_addr),
        .reg_data   (rt_data),
        .exmem_we   (exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_we   (memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .fwd_data   (w_rt_fwd),
        .fwd_hit    (w_rt_hit)
    );

    // The adder only uses OP as carry-in, so subtraction needs Y inverted here.
    always_comb begin
        w_accept = in_valid && r_in_ready;
        w_yb     = alu_src ? imm : w_rt_fwd;
        w_new.x    = w_rs_fwd;
        w_new.y    = sub ? ~w_yb : w_yb;
        w_new.op   = sub;
        w_new.dest = dest_in;
    end

    always_comb begin
        w_prim_nxt       = r_prim;
        w_skid_nxt       = r_skid;
        w_prim_valid_nxt = r_prim_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_prim_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_prim_valid || out_ready) begin
            if (r_skid_valid) begin
                // Oldest entry advances first; a same-cycle accept refills the skid.
                w_prim_nxt       = r_skid;
                w_prim_valid_nxt = 1'b1;
                if (w_accept) begin
                    w_skid_nxt       = w_new;
                    w_skid_valid_nxt = 1'b1;
                end else begin
                    w_skid_valid_nxt = 1'b0;
                end
            end else if (w_accept) begin
                w_prim_nxt       = w_new;
                w_prim_valid_nxt = 1'b1;
            end else begin
                w_prim_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_nxt       = w_new;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prim       <= '0;
            r_skid       <= '0;
            r_prim_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_prim       <= w_prim_nxt;
            r_skid       <= w_skid_nxt;
            r_prim_valid <= w_prim_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

`ifdef EX_OPERAND_FWD_CNT_EN
    logic [15:0] r_fwd_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fwd_cnt <= '0;
        end else if (w_accept && (w_rs_hit || w_rt_hit) && (r_fwd_cnt != 16'hFFFF)) begin
            r_fwd_cnt <= r_fwd_cnt + 16'd1;
        end
    end

    assign fwd_cnt = r_fwd_cnt;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = w_rs_hit | w_rt_hit;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_prim_valid;
    assign x_out     = r_prim.x;
    assign y_out     = r_prim.y;
    assign op_out    = r_prim.op;
    assign dest_out  = r_prim.dest;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_operand_stage
//  Description : Directed self-checking bench for ex_operand_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [3:0]  rs_addr, rt_addr, dest_in, exmem_rd, memwb_rd, dest_out;
    logic [15:0] rs_data, rt_data, imm, exmem_data, memwb_data, x_out, y_out;
    logic        alu_src, sub, exmem_we, memwb_we, out_valid, out_ready, op_out;
`ifdef EX_OPERAND_FWD_CNT_EN
    logic [15:0] fwd_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .alu_src(alu_src), .sub(sub), .dest_in(dest_in),
        .exmem_we(exmem_we), .memwb_we(memwb_we),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .op_out(op_out),
`ifdef EX_OPERAND_FWD_CNT_EN
        .fwd_cnt(fwd_cnt),
`endif
        .dest_out(dest_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0;
        rs_addr = 4'd3; rt_addr = 4'd4; rs_data = '0; rt_data = '0; imm = '0;
        alu_src = 1'b0; sub = 1'b0; dest_in = '0;
        exmem_we = 1'b0; memwb_we = 1'b0; exmem_rd = '0; memwb_rd = '0;
        exmem_data = '0; memwb_data = '0;
    endtask

    logic [16:0] sum;

    initial begin
        idle_inputs();
        rst_n = 1'b0; out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_x",         {16'd0, x_out},     32'd0);
        check("rst_y",         {16'd0, y_out},     32'd0);
        check("rst_op",        {31'd0, op_out},    32'd0);
        check("rst_dest",      {28'd0, dest_out},  32'd0);

        // Plain add, no forwarding
        rst_n = 1'b1;
        in_valid = 1'b1; rs_data = 16'h0005; rt_data = 16'h0003; dest_in = 4'd5;
        step();
        in_valid = 1'b0;
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_x",     {16'd0, x_out},     32'h0005);
        check("add_y",     {16'd0, y_out},     32'h0003);
        check("add_op",    {31'd0, op_out},    32'd0);
        check("add_dest",  {28'd0, dest_out},  32'd5);
        step();
        check("add_drained", {31'd0, out_valid}, 32'd0);

        // Subtract via immediate
        in_valid = 1'b1; rs_data = 16'h0010; imm = 16'h0001; alu_src = 1'b1; sub = 1'b1;
        step();
        idle_inputs();
        check("sub_y",  {16'd0, y_out},  32'hFFFE);
        check("sub_op", {31'd0, op_out}, 32'd1);
        sum = {1'b0, x_out} + {1'b0, y_out} + {16'd0, op_out};
        check("sub_result", {16'd0, sum[15:0]}, 32'h000F);

        // Forward priority: EX/MEM over MEM/WB on both operands
        in_valid = 1'b1; rs_addr = 4'd2; rt_addr = 4'd2; rs_data = 16'hAAAA; rt_data = 16'hBBBB;
        exmem_we = 1'b1; exmem_rd = 4'd2; exmem_data = 16'h1111;
        memwb_we = 1'b1; memwb_rd = 4'd2; memwb_data = 16'h2222;
        step();
        check("fwd_exmem_x", {16'd0, x_out}, 32'h1111);
        check("fwd_exmem_y", {16'd0, y_out}, 32'h1111);
        // Register zero is never forwarded
        rs_addr = 4'd0; rt_addr = 4'd4;
        step();
        check("fwd_r0_x", {16'd0, x_out}, 32'hAAAA);
        check("fwd_r0_y", {16'd0, y_out}, 32'hBBBB);
        // MEM/WB used when EX/MEM is not writing
        rs_addr = 4'd2; exmem_we = 1'b0;
        step();
        idle_inputs();
        check("fwd_memwb_x", {16'd0, x_out}, 32'h2222);
`ifdef EX_OPERAND_FWD_CNT_EN
        check("fwd_cnt_count", {16'd0, fwd_cnt}, 32'd2);
`endif
        step();
        check("fwd_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: three offers, two accepted, drained in order
        out_ready = 1'b0;
        in_valid = 1'b1; rs_data = 16'h0A01;
        step();
        check("bp_ready1", {31'd0, in_ready}, 32'd1);
        rs_data = 16'h0B02;
        step();
        check("bp_ready2", {31'd0, in_ready}, 32'd0);
        check("bp_x_a",    {16'd0, x_out},    32'h0A01);
        rs_data = 16'h0C03;
        step();
        check("bp_hold_x",     {16'd0, x_out},     32'h0A01);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_ready3",     {31'd0, in_ready},  32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_drain_b",     {16'd0, x_out},     32'h0B02);
        check("bp_drain_valid", {31'd0, out_valid}, 32'd1);
        check("bp_ready_back",  {31'd0, in_ready},  32'd1);
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush with skid full and an offer pending
        out_ready = 1'b0;
        in_valid = 1'b1; rs_data = 16'h0D04;
        step();
        rs_data = 16'h0E05;
        step();
        check("fl_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; rs_data = 16'h0F06;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready},  32'd1);
        step();
        check("fl_nothing", {31'd0, out_valid}, 32'd0);
        // Flush discards a same-cycle accept
        in_valid = 1'b1; flush = 1'b1; rs_data = 16'h0123;
        step();
        idle_inputs();
        check("fl_accept_dropped", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; rs_addr = 4'd7; exmem_we = 1'b1; exmem_rd = 4'd7;
        exmem_data = 16'h7777; imm = 16'h0042; alu_src = 1'b1; sub = 1'b1; dest_in = 4'd9;
        step();
        idle_inputs();
        check("mr_valid_before", {31'd0, out_valid}, 32'd1);
        check("mr_x_before",     {16'd0, x_out},     32'h7777);
        check("mr_y_before",     {16'd0, y_out},     32'hFFBD);
        rst_n = 1'b0;
        step();
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_ready", {31'd0, in_ready},  32'd1);
        check("mr_x",     {16'd0, x_out},     32'd0);
        check("mr_y",     {16'd0, y_out},     32'd0);
        check("mr_op",    {31'd0, op_out},    32'd0);
        check("mr_dest",  {28'd0, dest_out},  32'd0);
`ifdef EX_OPERAND_FWD_CNT_EN
        check("mr_fwd_cnt", {16'd0, fwd_cnt}, 32'd0);
`endif
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        check("mr_after", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Operand-preparation pipeline stage directly upstream of the 16-bit ripple adder (X, Y, OP inputs).
- Resolves the register-file operands through EX/MEM and MEM/WB forwarding and selects register or immediate for Y.
- Pre-inverts Y for subtraction, because the adder applies OP only as carry-in and does not invert Y itself.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput with a registered ready.

Parameters:
- WIDTH, 16: datapath width; equals the adder width.
- RAW, 4: register-address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all held entries (branch/exception kill).
- in_valid  in  1  upstream offers an operation.
- in_ready  out  1  stage can accept; registered.
- rs_addr, rt_addr  in  RAW  source register numbers.
- rs_data, rt_data  in  WIDTH  register-file read data.
- imm  in  WIDTH  sign-extended immediate.
- alu_src  in  1  1 = Y from imm, 0 = Y from rt.
- sub  in  1  1 = subtract.
- dest_in  in  RAW  destination register, passed through.
- exmem_we, memwb_we  in  1  forwarding-source write enables.
- exmem_rd, memwb_rd  in  RAW  forwarding-source destinations.
- exmem_data, memwb_data  in  WIDTH  forwarding-source values.
- out_valid  out  1  X/Y/OP are valid.
- out_ready  in  1  adder stage consumes.
- x_out, y_out  out  WIDTH  adder X and Y.
- op_out  out  1  adder OP (carry-in).
- dest_out  out  RAW  destination register.

Behaviour:
- Reset: while rst_n=0 at a rising edge, all state clears. out_valid=0, in_ready=1, x_out=y_out=0, op_out=0, dest_out=0; skid entry is empty.
- Accept occurs when in_valid & in_ready at an edge. Forwarding and muxing are evaluated combinationally from the inputs in that same cycle.
- Forwarding for rs (rt is identical):
  - exmem_we & exmem_rd==rs_addr & rs_addr!=0 → exmem_data.
  - Else memwb_we & memwb_rd==rs_addr & rs_addr!=0 → memwb_data.
  - Else rs_data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
  - Forwarding applies only at accept. Held entries are not re-forwarded; the hazard unit guarantees no later dependency.
- Y select: yb = alu_src ? imm : rt_fwd. Then y_out = sub ? ~yb : yb, op_out = sub. The adder therefore computes X + ~Y + 1.
- Latency: 1 cycle from accept to out_valid when the output register is empty or draining.
- Storage: output register (primary) plus one skid entry. in_ready = ~skid_valid, registered.
- Per-edge transitions, evaluated in priority order:
  - flush=1: out_valid=0 and skid_valid=0. An input accepted in the same cycle is discarded.
  - Primary empty or out_ready=1: primary loads the skid entry if the skid is valid, else the accepted input. If neither exists, out_valid=0.
  - Primary full, out_ready=0, accept: input goes to the skid entry and in_ready falls next cycle.
  - Skid full, out_ready=1 and accept in the same cycle: skid moves to primary and the new input moves to skid. Order is preserved.
- Outputs hold stable while out_valid & ~out_ready.
- Held data registers are not cleared on flush; only the valids are.
- Reset mid-operation: all entries are lost and nothing is emitted the following cycle.

Optional Feature:
- Macro EX_OPERAND_FWD_CNT_EN.
- Defined: adds output fwd_cnt [15:0], a saturating count (stops at 16'hFFFF) of accepts where either operand was forwarded. Cleared by reset; flush does not clear it.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package ex_pkg:
  - WIDTH and RAW defaults.
  - Typedef operand bundle {x, y, op, dest}, used by both skid slots.
  - Constant REG_ZERO.
- Sub-module fwd_mux: pure combinational per-operand forwarding select, instantiated twice (rs, rt).

Test Plan:
- Reset then add: rs=3/rs_data=0x0005, rt=4/rt_data=0x0003, sub=0, no forwarding → next cycle out_valid=1, x=0x0005, y=0x0003, op=0.
- Sub via immediate: rs_data=0x0010, imm=0x0001, alu_src=1, sub=1 → y=0xFFFE, op=1; adder result 0x000F.
- Forward priority: rs_addr=2, exmem_rd=2 (0x1111), memwb_rd=2 (0x2222), both we=1 → x=0x1111. With rs_addr=0 and the same forwards → x=rs_data.
- Backpressure: out_ready=0, three back-to-back in_valid → two accepted, in_ready=0 on cycle 3. out_ready=1 then drains both in order with no loss or duplication.
- Flush: skid full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emitted.
- Reset mid-stream: rst_n=0 for one edge while out_valid=1 → all outputs return to reset values. With EX_OPERAND_FWD_CNT_EN defined, fwd_cnt=0.
